lcd_fb_arbiter: RTL and testbench
=================================

# lcd_fb_arbiter

Single-port frame-buffer arbiter between LCD scan-out and a host pixel writer, with vsync-synchronised double buffering. Sits between the LCD timing controller (DE, active-low VSYNC, linear scan address) and one single-port BRAM holding two pages. Scan-out has absolute priority during active video. Host writes are buffered in a FIFO and drained during blanking. Page flips happen only at the start of a VSYNC pulse, so the panel never shows a torn frame.

## Interface
- ABW, 19, pixel address width within one page (800×480 fits)
- DW, 16, pixel data width
- WFIFO_AW, 4, log2 of write-FIFO depth (default 16 entries)

- iCLK  in  1  pixel clock, same clock as the timing controller
- inRST  in  1  asynchronous, active-low reset
- iDE  in  1  active-video enable from the timing controller
- iVSYNC  in  1  vertical sync, active low
- iADDR  in  ABW  linear scan address, valid when iDE=1
- iWR_VALID  in  1  host write request
- iWR_ADDR  in  ABW  host pixel address in the draw page
- iWR_DATA  in  DW  host pixel data
- oWR_READY  out  1  write accepted this cycle when high together with iWR_VALID
- iFLIP_REQ  in  1  single-cycle pulse: swap pages at the next VSYNC
- oFLIP_PEND  out  1  flip requested, not yet done
- oFLIP_ACK  out  1  single-cycle pulse when the swap takes effect
- oDISP_PAGE  out  1  page currently scanned out
- oBRAM_EN  out  1  BRAM port enable
- oBRAM_WE  out  1  BRAM write enable
- oBRAM_ADDR  out  ABW+1  {page, pixel address}
- oBRAM_WDATA  out  DW  BRAM write data
- iBRAM_RDATA  in  DW  BRAM read data, one-cycle read latency
- oPIXEL  out  DW  pixel to the panel
- oPIXEL_VALID  out  1  oPIXEL is a valid active pixel

## Operation
- Pages: disp_page is the page scanned out; draw_page = ~disp_page. Reset sets disp_page=0.
- Read slot, when iDE=1:
  - oBRAM_EN=1, oBRAM_WE=0, oBRAM_ADDR={disp_page, iADDR}.
  - No write is issued in that cycle.
- Write slot, when iDE=0 and the FIFO is non-empty:
  - Pop the head entry.
  - oBRAM_EN=1, oBRAM_WE=1, oBRAM_ADDR={draw_page, addr}, oBRAM_WDATA=data.
- Idle, when neither slot is active: oBRAM_EN=0, oBRAM_WE=0. Address and data hold their last value.
- Write FIFO:
  - Depth 2^WFIFO_AW, entries {addr, data}.
  - oWR_READY = ~full & ~flip_pend.
  - Push and pop in the same cycle are allowed. Occupancy is unchanged.
  - Pushing when full is impossible because ready is low.
- Host addresses are not range-checked. They wrap modulo 2^ABW.
- Flip state machine:
  - IDLE: on iFLIP_REQ go to PEND.
  - PEND: flip_pend=1. Wait until the FIFO is empty and a VSYNC falling edge occurs (iVSYNC 1→0, detected against a registered copy whose reset value is 1). Then go to SWAP.
  - SWAP: disp_page toggles, oFLIP_ACK=1 for this one cycle, then return to IDLE.
- iFLIP_REQ while in PEND or SWAP is ignored; no queueing.
- A VSYNC fall in the same cycle as iFLIP_REQ does not flip. The flip waits for the next fall.
- A VSYNC fall while the FIFO is non-empty does not flip. The flip waits a full frame.
- Pixel output: valid_q <= iDE; oPIXEL = valid_q ? iBRAM_RDATA : 0; oPIXEL_VALID = valid_q.
- Reset mid-operation:
  - FIFO emptied, state returns to IDLE, disp_page=0, valid_q=0.
  - Any pending flip and any unwritten entries are discarded.

## Timing
- Reset values: oWR_READY=1, oFLIP_PEND=0, oFLIP_ACK=0, oDISP_PAGE=0, oBRAM_EN=0, oBRAM_WE=0, oBRAM_ADDR=0, oBRAM_WDATA=0, oPIXEL=0, oPIXEL_VALID=0.
- BRAM control outputs are combinational from iDE, iADDR, FIFO head and disp_page, all of which are in the iCLK domain.
- Pixel latency: iDE/iADDR at cycle n → oPIXEL at cycle n+1.
- Write latency, minimum:
  - Host handshake at cycle n → BRAM write at cycle n+1, if iDE=0.
  - Otherwise the write is deferred to the first iDE=0 cycle.
- Drain throughput: one entry per blanking cycle.
- Flip: the VSYNC fall is detected in cycle n; SWAP, the oFLIP_ACK pulse and the new oDISP_PAGE all appear at cycle n+1. oFLIP_PEND drops at n+1.

## Structure
- Shared package `lcd_pkg`: ABW/DW defaults and the flip-state encoding (IDLE, PEND, SWAP).
- One sub-module, `lcd_wr_fifo`: synchronous FIFO, parameterised width and depth, with full/empty flags. It is reused by other host-side LCD blocks.
- The arbiter top holds the slot mux, the flip state machine, the VSYNC edge detect and the pixel-valid register.

## Test plan
- Scan-only: drive iDE high for 800 cycles with iADDR=0..799 and a BRAM model → oBRAM_ADDR={0, iADDR}, oPIXEL equals model data one cycle later, oBRAM_WE never set.
- Blanking drain: push 16 writes during iDE=1 → oWR_READY falls after the 16th. After iDE falls, 16 consecutive writes appear at {1, addr} in push order.
- Collision: iWR_VALID held with iDE toggling 1/0 every cycle → writes occur only in iDE=0 cycles, and no read slot is ever lost.
- Flip with empty FIFO: iFLIP_REQ, then a VSYNC fall → oFLIP_ACK one cycle after the fall, oDISP_PAGE 0→1, and subsequent writes target page 0.
- Flip blocked: iFLIP_REQ with 3 entries queued and the VSYNC fall occurring during iDE=1 → no flip that frame. The flip occurs at the next VSYNC fall, and oWR_READY stays 0 throughout PEND.
- Reset mid-PEND with a non-empty FIFO: pulse inRST low → all outputs reach their reset values, no further BRAM writes occur, and oDISP_PAGE=0.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD frame-buffer blocks.
package lcd_pkg;
  localparam int ABW_DEF      = 19;  // pixel address width within one page
  localparam int DW_DEF       = 16;  // pixel data width
  localparam int WFIFO_AW_DEF = 4;   // log2 of host write-FIFO depth

  // Page-flip state machine encoding
  typedef enum logic [1:0] {
    FLIP_IDLE = 2'd0,
    FLIP_PEND = 2'd1,
    FLIP_SWAP = 2'd2
  } flipState_e;
endpackage

// File: rtl/lcd_wr_fifo.sv
// Synchronous FIFO with full/empty flags; the head entry is visible on oData
// without a pop so the consumer can use it in the same cycle it pops.
module lcd_wr_fifo #(
  parameter int W  = 35,
  parameter int AW = 4
) (
  input  logic         iCLK,
  input  logic         inRST,
  input  logic         iPush,
  input  logic         iPop,
  input  logic [W-1:0] iData,
  output logic [W-1:0] oData,
  output logic         oFull,
  output logic         oEmpty
);
  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [AW:0]   count;
  logic          doPush, doPop;

  assign doPush = iPush & ~oFull;
  assign doPop  = iPop & ~oEmpty;
  assign oFull  = (count == (AW+1)'(DEPTH));
  assign oEmpty = (count == '0);
  assign oData  = mem[rdPtr];

  // Storage array; contents need no reset, the pointers define validity
  always_ff @(posedge iCLK) begin
    if (doPush) mem[wrPtr] <= iData;
  end

  // Pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge iCLK or negedge inRST) begin
    if (!inRST) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      count <= count + {{AW{1'b0}}, doPush} - {{AW{1'b0}}, doPop};
    end
  end
endmodule

// File: rtl/lcd_fb_arbiter.sv
// Single-port frame-buffer arbiter: scan-out reads own the BRAM during active
// video, buffered host writes drain during blanking, and page flips are
// deferred to a VSYNC falling edge with the write FIFO empty.
module lcd_fb_arbiter
  import lcd_pkg::*;
#(
  parameter int ABW      = ABW_DEF,
  parameter int DW       = DW_DEF,
  parameter int WFIFO_AW = WFIFO_AW_DEF
) (
  input  logic           iCLK,
  input  logic           inRST,
  input  logic           iDE,
  input  logic           iVSYNC,
  input  logic [ABW-1:0] iADDR,
  input  logic           iWR_VALID,
  input  logic [ABW-1:0] iWR_ADDR,
  input  logic [DW-1:0]  iWR_DATA,
  output logic           oWR_READY,
  input  logic           iFLIP_REQ,
  output logic           oFLIP_PEND,
  output logic           oFLIP_ACK,
  output logic           oDISP_PAGE,
  output logic           oBRAM_EN,
  output logic           oBRAM_WE,
  output logic [ABW:0]   oBRAM_ADDR,
  output logic [DW-1:0]  oBRAM_WDATA,
  input  logic [DW-1:0]  iBRAM_RDATA,
  output logic [DW-1:0]  oPIXEL,
  output logic           oPIXEL_VALID
);
  typedef struct packed {
    logic [ABW-1:0] addr;
    logic [DW-1:0]  data;
  } wrEntry_t;

  wrEntry_t   fifoIn, fifoHead;
  logic       fifoFull, fifoEmpty, push, pop;
  flipState_e state;
  logic       dispPage, vsyncQ, vsyncFall, validQ;
  logic [ABW:0]  addrQ;
  logic [DW-1:0] wdataQ;

  // Host writes are blocked while a flip waits, so the FIFO can empty out
  assign oWR_READY = ~fifoFull & ~oFLIP_PEND;
  assign push      = iWR_VALID & oWR_READY;
  assign pop       = ~iDE & ~fifoEmpty;
  assign fifoIn    = {iWR_ADDR, iWR_DATA};
  assign vsyncFall = vsyncQ & ~iVSYNC;
  assign oDISP_PAGE = dispPage;

  lcd_wr_fifo #(.W($bits(wrEntry_t)), .AW(WFIFO_AW)) uWrFifo (
    .iCLK   (iCLK),
    .inRST  (inRST),
    .iPush  (push),
    .iPop   (pop),
    .iData  (fifoIn),
    .oData  (fifoHead),
    .oFull  (fifoFull),
    .oEmpty (fifoEmpty)
  );

  // Slot mux: scan read wins when DE is high, otherwise drain one write
  always_comb begin
    oBRAM_EN    = iDE | pop;
    oBRAM_WE    = pop;
    oBRAM_ADDR  = addrQ;
    oBRAM_WDATA = pop ? fifoHead.data : wdataQ;
    if (iDE)      oBRAM_ADDR = {dispPage, iADDR};
    else if (pop) oBRAM_ADDR = {~dispPage, fifoHead.addr};
  end

  // Remember last address/data so idle cycles hold them steady
  always_ff @(posedge iCLK or negedge inRST) begin
    if (!inRST) begin
      addrQ  <= '0;
      wdataQ <= '0;
    end else begin
      addrQ  <= oBRAM_ADDR;
      wdataQ <= oBRAM_WDATA;
    end
  end

  // VSYNC falling-edge detect and pixel-valid pipeline
  always_ff @(posedge iCLK or negedge inRST) begin
    if (!inRST) begin
      vsyncQ <= 1'b1;
      validQ <= 1'b0;
    end else begin
      vsyncQ <= iVSYNC;
      validQ <= iDE;
    end
  end

  assign oPIXEL_VALID = validQ;
  assign oPIXEL       = validQ ? iBRAM_RDATA : '0;

  // Flip FSM; requests arriving outside IDLE are dropped, not queued
  always_ff @(posedge iCLK or negedge inRST) begin
    if (!inRST) begin
      state      <= FLIP_IDLE;
      dispPage   <= 1'b0;
      oFLIP_PEND <= 1'b0;
      oFLIP_ACK  <= 1'b0;
    end else begin
      case (state)
        FLIP_IDLE: if (iFLIP_REQ) begin
          state      <= FLIP_PEND;
          oFLIP_PEND <= 1'b1;
        end
        FLIP_PEND: if (fifoEmpty && vsyncFall) begin
          state      <= FLIP_SWAP;
          dispPage   <= ~dispPage;
          oFLIP_PEND <= 1'b0;
          oFLIP_ACK  <= 1'b1;
        end
        FLIP_SWAP: begin
          state     <= FLIP_IDLE;
          oFLIP_ACK <= 1'b0;
        end
        default: begin
          state      <= FLIP_IDLE;
          oFLIP_PEND <= 1'b0;
          oFLIP_ACK  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_fb_arbiter.sv
// Scoreboard bench for lcd_fb_arbiter: a frame-level reference model predicts
// FIFO occupancy, flip state and page selection, queues expected writes and
// pixels, and a monitor pops them as the DUT presents writes and pixels.
module tb_lcd_fb_arbiter;
  localparam int ABW = 19;
  localparam int DW  = 16;
  localparam int NW  = 1 << (ABW + 1);

  logic           iCLK = 1'b0;
  logic           inRST;
  logic           iDE, iVSYNC, iWR_VALID, iFLIP_REQ;
  logic [ABW-1:0] iADDR, iWR_ADDR;
  logic [DW-1:0]  iWR_DATA;
  logic           oWR_READY, oFLIP_PEND, oFLIP_ACK, oDISP_PAGE;
  logic           oBRAM_EN, oBRAM_WE, oPIXEL_VALID;
  logic [ABW:0]   oBRAM_ADDR;
  logic [DW-1:0]  oBRAM_WDATA, iBRAM_RDATA, oPIXEL;

  int nTests = 0;
  int nFail  = 0;

  lcd_fb_arbiter #(.ABW(ABW), .DW(DW), .WFIFO_AW(4)) dut (
    .iCLK(iCLK), .inRST(inRST), .iDE(iDE), .iVSYNC(iVSYNC), .iADDR(iADDR),
    .iWR_VALID(iWR_VALID), .iWR_ADDR(iWR_ADDR), .iWR_DATA(iWR_DATA),
    .oWR_READY(oWR_READY), .iFLIP_REQ(iFLIP_REQ), .oFLIP_PEND(oFLIP_PEND),
    .oFLIP_ACK(oFLIP_ACK), .oDISP_PAGE(oDISP_PAGE), .oBRAM_EN(oBRAM_EN),
    .oBRAM_WE(oBRAM_WE), .oBRAM_ADDR(oBRAM_ADDR), .oBRAM_WDATA(oBRAM_WDATA),
    .iBRAM_RDATA(iBRAM_RDATA), .oPIXEL(oPIXEL), .oPIXEL_VALID(oPIXEL_VALID)
  );

  always #5 iCLK = ~iCLK;

  function automatic logic [DW-1:0] initVal(input logic [ABW:0] a);
    return a[15:0] ^ {a[19:16], 12'h5A3};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // BRAM model driven by the DUT port, one-cycle read latency
  logic [DW-1:0] bram [NW];
  logic [DW-1:0] bramRd;
  logic          bramInit = 1'b0;
  always @(posedge iCLK) begin
    if (!bramInit) begin
      for (int i = 0; i < NW; i++) bram[i] <= initVal((ABW+1)'(i));
      bramInit <= 1'b1;
    end else if (oBRAM_EN && oBRAM_WE) bram[oBRAM_ADDR] <= oBRAM_WDATA;
    if (oBRAM_EN && !oBRAM_WE) bramRd <= bram[oBRAM_ADDR];
  end
  assign iBRAM_RDATA = bramRd;

  // Reference frame-buffer contents as the specification says they should be
  logic [DW-1:0] refMem [NW];

  logic [ABW+DW:0] expWr[$];   // {page, addr, data}
  logic [DW-1:0]   expPix[$];

  // Reference model: occupancy count, flip phase, displayed page
  int   occ = 0;
  int   phase = 0;  // 0 idle, 1 waiting for flip, 2 flip cycle
  logic disp = 1'b0;
  logic vPrev = 1'b1;
  always @(negedge iCLK) begin
    logic rdy, fall, wasEmpty;
    if (!inRST) begin
      occ = 0; phase = 0; disp = 1'b0; vPrev = 1'b1;
      expWr.delete(); expPix.delete();
    end else begin
      rdy = (occ < 16) && (phase != 1);
      chk("wr_ready",   64'(oWR_READY),  64'(rdy));
      chk("flip_pend",  64'(oFLIP_PEND), 64'(phase == 1));
      chk("flip_ack",   64'(oFLIP_ACK),  64'(phase == 2));
      chk("disp_page",  64'(oDISP_PAGE), 64'(disp));
      chk("bram_en",    64'(oBRAM_EN),   64'(iDE || occ > 0));
      chk("bram_we",    64'(oBRAM_WE),   64'(!iDE && occ > 0));
      if (iDE) begin
        chk("rd_addr", 64'(oBRAM_ADDR), 64'({disp, iADDR}));
        expPix.push_back(refMem[{disp, iADDR}]);
      end
      if (iWR_VALID && rdy) expWr.push_back({~disp, iWR_ADDR, iWR_DATA});
      fall = vPrev && !iVSYNC;
      vPrev = iVSYNC;
      wasEmpty = (occ == 0);
      occ = occ + ((iWR_VALID && rdy) ? 1 : 0) - ((!iDE && occ > 0) ? 1 : 0);
      if (phase == 0 && iFLIP_REQ) phase = 1;
      else if (phase == 1 && wasEmpty && fall) begin phase = 2; disp = ~disp; end
      else if (phase == 2) phase = 0;
    end
  end

  // Monitor: consumes expected writes/pixels whenever the DUT presents them
  always @(negedge iCLK) begin
    logic [ABW+DW:0] w;
    logic [DW-1:0]   p;
    if (inRST) begin
      if (oPIXEL_VALID) begin
        if (expPix.size() == 0) chk("pixel_unexpected", 64'(oPIXEL_VALID), 64'(0));
        else begin p = expPix.pop_front(); chk("pixel", 64'(oPIXEL), 64'(p)); end
      end else chk("pixel_idle", 64'(oPIXEL), 64'(0));
      if (oBRAM_WE) begin
        if (expWr.size() == 0) chk("write_unexpected", 64'(oBRAM_WE), 64'(0));
        else begin
          w = expWr.pop_front();
          chk("wr_addr", 64'(oBRAM_ADDR), 64'(w[ABW+DW:DW]));
          chk("wr_data", 64'(oBRAM_WDATA), 64'(w[DW-1:0]));
          refMem[w[ABW+DW:DW]] = w[DW-1:0];
        end
      end
    end
  end

  task automatic cyc(input logic de, input logic [ABW-1:0] ad, input logic wv,
                     input logic [ABW-1:0] wa, input logic [DW-1:0] wd,
                     input logic fr, input logic vs);
    iDE = de; iADDR = ad; iWR_VALID = wv; iWR_ADDR = wa; iWR_DATA = wd;
    iFLIP_REQ = fr; iVSYNC = vs;
    @(posedge iCLK); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  task automatic chkReset();
    chk("rst_ready", 64'(oWR_READY), 64'(1));
    chk("rst_pend",  64'(oFLIP_PEND), 64'(0));
    chk("rst_ack",   64'(oFLIP_ACK), 64'(0));
    chk("rst_page",  64'(oDISP_PAGE), 64'(0));
    chk("rst_en",    64'(oBRAM_EN), 64'(0));
    chk("rst_we",    64'(oBRAM_WE), 64'(0));
    chk("rst_addr",  64'(oBRAM_ADDR), 64'(0));
    chk("rst_wdata", 64'(oBRAM_WDATA), 64'(0));
    chk("rst_pixel", 64'(oPIXEL), 64'(0));
    chk("rst_pvld",  64'(oPIXEL_VALID), 64'(0));
  endtask

  initial begin
    int vcnt;
    for (int i = 0; i < NW; i++) refMem[i] = initVal((ABW+1)'(i));
    inRST = 1'b0;
    iDE = 0; iADDR = '0; iWR_VALID = 0; iWR_ADDR = '0; iWR_DATA = '0;
    iFLIP_REQ = 0; iVSYNC = 1;
    repeat (3) @(posedge iCLK);
    @(negedge iCLK); chkReset();
    @(posedge iCLK); #1; inRST = 1'b1;
    idle(2);

    // Scan-only: one full line of reads from page 0
    for (int i = 0; i < 800; i++) cyc(1'b1, ABW'(i), 1'b0, '0, '0, 1'b0, 1'b1);

    // Fill the FIFO during active video (plus overflow attempts), then drain
    for (int i = 0; i < 20; i++)
      cyc(1'b1, ABW'(i), 1'b1, ABW'(i * 3), DW'($urandom), 1'b0, 1'b1);
    idle(20);

    // Collision: writes offered every cycle while DE toggles
    for (int i = 0; i < 60; i++)
      cyc(1'(i % 2 == 0), ABW'($urandom), 1'b1, ABW'($urandom), DW'($urandom), 1'b0, 1'b1);
    idle(20);

    // Flip request coinciding with a VSYNC fall: must wait for the next fall
    cyc(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
    idle(0);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    idle(5);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    idle(3);
    // Writes now land in page 0; scan page 1 to see the earlier drained data
    for (int i = 0; i < 4; i++)
      cyc(1'b0, '0, 1'b1, ABW'(i * 3), DW'($urandom), 1'b0, 1'b1);
    idle(6);
    for (int i = 0; i < 60; i++) cyc(1'b1, ABW'(i), 1'b0, '0, '0, 1'b0, 1'b1);
    idle(4);

    // Flip blocked: entries queued and VSYNC falls during active video
    for (int i = 0; i < 3; i++)
      cyc(1'b1, ABW'(i), 1'b1, ABW'($urandom), DW'($urandom), 1'b0, 1'b1);
    cyc(1'b1, '0, 1'b0, '0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++)
      cyc(1'b1, ABW'(i), 1'b1, ABW'($urandom), DW'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      cyc(1'b0, '0, 1'b1, ABW'($urandom), DW'($urandom), 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    idle(5);

    // Randomized mix of scan, writes, flips and VSYNC pulses
    vcnt = 0;
    for (int i = 0; i < 1500; i++) begin
      vcnt = (vcnt + 1) % 97;
      cyc(1'($urandom_range(0, 2) != 0), ABW'($urandom), 1'($urandom_range(0, 1)),
          ABW'($urandom), DW'($urandom), 1'($urandom_range(0, 39) == 0), 1'(vcnt >= 4));
    end
    idle(30);

    // Reset while a flip is pending with entries queued
    for (int i = 0; i < 5; i++)
      cyc(1'b1, ABW'(i), 1'b1, ABW'($urandom), DW'($urandom), 1'b0, 1'b1);
    cyc(1'b1, '0, 1'b0, '0, '0, 1'b1, 1'b1);
    cyc(1'b1, '0, 1'b0, '0, '0, 1'b0, 1'b1);
    iDE = 1'b0; iWR_VALID = 1'b0; #2; inRST = 1'b0;
    @(negedge iCLK); chkReset();
    @(posedge iCLK); #1;
    @(negedge iCLK); chkReset();
    @(posedge iCLK); #1; inRST = 1'b1;
    idle(20);
    for (int i = 0; i < 20; i++) cyc(1'b1, ABW'(i * 3), 1'b0, '0, '0, 1'b0, 1'b1);
    idle(5);

    chk("writes_left", 64'(expWr.size()), 64'(0));
    chk("pixels_left", 64'(expPix.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
